// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, FSM
// states, loop length and architectural special-case results.
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    localparam int          MDU_ITERS = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } mdu_state_e;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Decoder-to-MDU handshake bundle; master is the issuing stage, slave the MDU.
interface mdu_sequencer_if #(parameter int XLEN = 32);

    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] A_i;
    logic [XLEN-1:0] B_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, A_i, B_i, kill_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, A_i, B_i, kill_i,
        output busy_o, done_o, result_o
    );

endinterface

// File: rtl/mdu_step.sv
// Shared 33-bit add/subtract step; co_o is carry out (for subtract, 1 = no borrow).
module mdu_step (
    input  logic [32:0] a_i,
    input  logic [32:0] b_i,
    input  logic        sub_i,
    output logic [32:0] sum_o,
    output logic        co_o
);

    logic [32:0] b_eff;

    always_comb begin
        b_eff          = sub_i ? ~b_i : b_i;
        {co_o, sum_o}  = {1'b0, a_i} + {1'b0, b_eff} + {33'd0, sub_i};
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide).
// Define MDU_FAST_SPECIAL_EN to resolve div-by-zero, overflow and zero multiply in PREP.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    mdu_sequencer_if.slave  bus
);

    mdu_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;

    logic              is_div, a_sgn, b_sgn, a_neg, b_neg, res_neg;
    logic              div0, ovf, mul_zero;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, fix_res;
    logic [2*XLEN-1:0] prod;
    logic [32:0]       step_a, step_b, step_sum;
    logic              step_co;

    // Operands stay latched for the whole operation, so signs and special
    // cases are decoded combinationally instead of being stored.
    always_comb begin
        is_div   = op_q[2];
        a_sgn    = (op_q == MDU_MULH) || (op_q == MDU_MULHSU) ||
                   (op_q == MDU_DIV)  || (op_q == MDU_REM);
        b_sgn    = (op_q == MDU_MULH) || (op_q == MDU_DIV) || (op_q == MDU_REM);
        a_neg    = a_sgn & a_q[XLEN-1];
        b_neg    = b_sgn & b_q[XLEN-1];
        res_neg  = a_neg ^ b_neg;
        a_mag    = neg_if(a_neg, a_q);
        b_mag    = neg_if(b_neg, b_q);
        div0     = is_div && (b_q == '0);
        ovf      = ((op_q == MDU_DIV) || (op_q == MDU_REM)) &&
                   (a_q == OVF_QUOT) && (b_q == DIV0_QUOT);
        mul_zero = !is_div && ((a_q == '0) || (b_q == '0));

        special_res = '0;
        if (div0) special_res = op_q[1] ? a_q : DIV0_QUOT;
        else if (ovf && !op_q[1]) special_res = OVF_QUOT;

        prod = res_neg ? (~acc_q + 64'd1) : acc_q;
        unique case (op_q)
            MDU_MUL:                        fix_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              fix_res = neg_if(res_neg, acc_q[XLEN-1:0]);
            default:                        fix_res = neg_if(a_neg, acc_q[2*XLEN-1:XLEN]);
        endcase
    end

    // Multiply adds the multiplicand to the upper half; divide subtracts the
    // divisor from the 33-bit shifted partial remainder.
    always_comb begin
        step_a = is_div ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
        step_b = {1'b0, opnd_q};
    end

    mdu_step u_step (
        .a_i   (step_a),
        .b_i   (step_b),
        .sub_i (is_div),
        .sum_o (step_sum),
        .co_o  (step_co)
    );

    // NOTE: every _d gets its hold value first so no path through the case
    // below leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    op_d    = bus.funct3_i;
                    a_d     = bus.A_i;
                    b_d     = bus.B_i;
                    state_d = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                opnd_d  = is_div ? b_mag : a_mag;
                cnt_d   = '0;
                state_d = S_ITER;
`ifdef MDU_FAST_SPECIAL_EN
                if (div0 || ovf || mul_zero) begin
                    result_d = special_res;
                    state_d  = S_DONE;
                end
`endif
            end
            S_ITER: begin
                if (is_div) begin
                    acc_d = step_co ? {step_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                                    : {acc_q[2*XLEN-2:0], 1'b0};
                end else begin
                    acc_d = acc_q[0] ? {step_sum, acc_q[XLEN-1:1]}
                                     : {1'b0, acc_q[2*XLEN-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MDU_ITERS - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = (div0 || ovf) ? special_res : fix_res;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush abandons the operation and must not disturb the old result.
        if (bus.kill_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= MDU_MUL;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy_o   = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed RV32M cases, kill/reset,
// back-to-back issue and randomized ops against a 64-bit arithmetic model.
module tb_mdu_sequencer;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam int TIMEOUT = 100;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    mdu_sequencer_if bus ();

    mdu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ps;
        longint unsigned ua, ub, pu;
        int              ia, ib, q;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (op)
            OP_MUL:    begin ps = sa * sb; p = ps; return p[31:0];  end
            OP_MULH:   begin ps = sa * sb; p = ps; return p[63:32]; end
            OP_MULHSU: begin ps = sa * longint'(ub); p = ps; return p[63:32]; end
            OP_MULHU:  begin pu = ua * ub; p = pu; return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ia / ib;
                return q;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = ia % ib;
                return q;
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (op[2] && b == 0) ||
                  ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                  (!op[2] && (a == 0 || b == 0));
`ifdef MDU_FAST_SPECIAL_EN
        return special ? 1 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; the next posedge samples the request (E0) and the
    // task returns at the negedge after E0.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i  = 1'b1;
        bus.funct3_i = op;
        bus.A_i      = a;
        bus.B_i      = b;
        @(negedge clk);
        bus.start_i  = 1'b0;
    endtask

    // Counts edges after E0 until done_o is seen; stays in the done cycle.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (bus.done_o !== 1'b1 && lat < TIMEOUT) begin
            if (bus.busy_o === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_n);
        start_op(op, a, b);
        wait_done(lat, busy_n);
        res = bus.result_o;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        tests_run++; if (bus.done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        tests_run++; if (bus.result_o !== 32'd0) begin tests_failed++; $display("FAIL reset_result got %h want 0", bus.result_o); end
        reset = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL idle_busy got %b want 0", bus.busy_o); end
    endtask

    task automatic test_directed();
        vec_t        tbl[14];
        logic [31:0] res;
        int          lat, busy_n;
        tbl[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tbl[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        tbl[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        tbl[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14};
        tbl[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2};
        tbl[8]  = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
        tbl[9]  = '{OP_REM,    32'd5,         32'd0,         32'd5};
        tbl[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        tbl[12] = '{OP_MUL,    32'd0,         32'd12345,     32'd0};
        tbl[13] = '{OP_MULHU,  32'h1234_5678, 32'd0,         32'd0};
        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, busy_n);
            tests_run++; if (res !== tbl[i].exp) begin tests_failed++; $display("FAIL dir%0d_result got %h want %h", i, res, tbl[i].exp); end
            tests_run++; if (lat !== exp_lat(tbl[i].op, tbl[i].a, tbl[i].b)) begin tests_failed++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_lat(tbl[i].op, tbl[i].a, tbl[i].b)); end
            tests_run++; if (busy_n !== exp_lat(tbl[i].op, tbl[i].a, tbl[i].b)) begin tests_failed++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, busy_n, exp_lat(tbl[i].op, tbl[i].a, tbl[i].b)); end
            @(negedge clk);
            tests_run++; if (bus.done_o !== 1'b0) begin tests_failed++; $display("FAIL dir%0d_done_pulse got %b want 0", i, bus.done_o); end
            tests_run++; if (bus.result_o !== tbl[i].exp) begin tests_failed++; $display("FAIL dir%0d_result_hold got %h want %h", i, bus.result_o, tbl[i].exp); end
        end
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int          lat, busy_n, done_seen;
        run_op(OP_MUL, 32'd3, 32'd5, res, lat, busy_n);
        @(negedge clk);
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL kill_busy got %b want 0", bus.busy_o); end
        tests_run++; if (bus.result_o !== 32'd15) begin tests_failed++; $display("FAIL kill_result got %h want %h", bus.result_o, 32'd15); end
        done_seen = 0;
        repeat (40) begin
            if (bus.done_o === 1'b1) done_seen++;
            @(negedge clk);
        end
        tests_run++; if (done_seen !== 0) begin tests_failed++; $display("FAIL kill_no_done got %0d want 0", done_seen); end
        bus.kill_i = 1'b1;
        start_op(OP_MUL, 32'd2, 32'd2);
        bus.kill_i = 1'b0;
        tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL kill_over_start got %b want 0", bus.busy_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat, busy_n;
        start_op(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got %b want 0", bus.busy_o); end
        tests_run++; if (bus.done_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_done got %b want 0", bus.done_o); end
        @(negedge clk);
        reset = 1'b0;
        tests_run++; if (bus.result_o !== 32'd0) begin tests_failed++; $display("FAIL rst_mid_result got %h want 0", bus.result_o); end
        run_op(OP_DIVU, 32'd12, 32'd4, res, lat, busy_n);
        tests_run++; if (res !== 32'd3) begin tests_failed++; $display("FAIL rst_after_result got %h want 3", res); end
        tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL rst_after_latency got %0d want 34", lat); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat, busy_n, lat2, done_seen;
        run_op(OP_MUL, 32'd3, 32'd4, res, lat, busy_n);
        tests_run++; if (res !== 32'd12) begin tests_failed++; $display("FAIL b2b_first got %h want 12", res); end
        start_op(OP_DIVU, 32'd12, 32'd4);
        tests_run++; if (bus.busy_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_no_gap got %b want 1", bus.busy_o); end
        wait_done(lat, busy_n);
        tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL b2b_spacing got %0d want 34", lat); end
        tests_run++; if (bus.result_o !== 32'd3) begin tests_failed++; $display("FAIL b2b_second got %h want 3", bus.result_o); end
        @(negedge clk);
        start_op(OP_MUL, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        start_op(OP_DIVU, 32'd1, 32'd1);
        wait_done(lat2, busy_n);
        tests_run++; if (lat2 + 6 !== 34) begin tests_failed++; $display("FAIL iter_start_latency got %0d want 34", lat2 + 6); end
        tests_run++; if (bus.result_o !== 32'd30) begin tests_failed++; $display("FAIL iter_start_result got %h want %h", bus.result_o, 32'd30); end
        @(negedge clk);
        done_seen = 0;
        repeat (40) begin
            if (bus.done_o === 1'b1) done_seen++;
            @(negedge clk);
        end
        tests_run++; if (done_seen !== 0) begin tests_failed++; $display("FAIL iter_start_ignored got %0d want 0", done_seen); end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        int          lat, busy_n;
        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom_range(0, 7));
            a   = rand_operand();
            b   = rand_operand();
            exp = ref_result(op, a, b);
            run_op(op, a, b, res, lat, busy_n);
            tests_run++; if (res !== exp) begin tests_failed++; $display("FAIL rand%0d op=%0d a=%h b=%h got %h want %h", n, op, a, b, res, exp); end
            tests_run++; if (lat !== exp_lat(op, a, b)) begin tests_failed++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, exp_lat(op, a, b)); end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.kill_i   = 1'b0;
        bus.funct3_i = 3'd0;
        bus.A_i      = 32'd0;
        bus.B_i      = 32'd0;
        test_reset();
        test_directed();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
